// File: rtl/hour_set_ctrl_if.sv
// Hour-setting bus: button level and minute carry in, hour register and status out.
interface hour_set_ctrl_if;
    logic       debounced;
    logic       hourCarry;
    logic [4:0] hour;
    logic [1:0] hourTens;
    logic [3:0] hourUnits;
    logic       dayCarry;
    logic       setActive;

    modport master (
        output debounced, hourCarry,
        input  hour, hourTens, hourUnits, dayCarry, setActive
    );

    modport slave (
        input  debounced, hourCarry,
        output hour, hourTens, hourUnits, dayCarry, setActive
    );
endinterface

// File: rtl/hour_set_ctrl.sv
// Hour register with button press/auto-repeat stepping and minute-carry timekeeping.
// state  | meaning
// IDLE   | button released, waiting for a rising edge
// HOLD   | press step done, timing the initial hold delay
// REPEAT | auto-repeat, one step every REPEAT_CYCLES while held
module hour_set_ctrl #(
    parameter int HOLD_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int HOURS         = 24
) (
    input logic           Clk_100M,
    input logic           nReset,
    hour_set_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam logic [4:0]  LAST_HOUR = 5'(HOURS - 1);
    localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);
    localparam logic [26:0] REP_LAST  = 27'(REPEAT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic        btn_q, btn_d;
    logic [4:0]  hour_q, hour_d;
    logic [1:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic        day_carry_q, day_carry_d;
    logic        set_active_q, set_active_d;
    logic        rise, step;
    logic [4:0]  t_hour;

    always_comb begin
        rise    = bus.debounced & ~btn_q;
        btn_d   = bus.debounced;
        step    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.debounced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            REPEAT: begin
                if (!bus.debounced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Timekeeping carry is applied before the manual step.
        t_hour = bus.hourCarry ? ((hour_q == LAST_HOUR) ? 5'd0 : hour_q + 5'd1) : hour_q;
        hour_d = step ? ((t_hour == LAST_HOUR) ? 5'd0 : t_hour + 5'd1) : t_hour;

        day_carry_d  = bus.hourCarry & (hour_q == LAST_HOUR);
        set_active_d = (state_q != IDLE);

        if (hour_d >= 5'd20) begin
            tens_d  = 2'd2;
            units_d = 4'(hour_d - 5'd20);
        end else if (hour_d >= 5'd10) begin
            tens_d  = 2'd1;
            units_d = 4'(hour_d - 5'd10);
        end else begin
            tens_d  = 2'd0;
            units_d = 4'(hour_d);
        end
    end

    always_ff @(posedge Clk_100M or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            btn_q        <= 1'b1;
            hour_q       <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            day_carry_q  <= 1'b0;
            set_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            btn_q        <= btn_d;
            hour_q       <= hour_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            day_carry_q  <= day_carry_d;
            set_active_q <= set_active_d;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.hourTens  = tens_q;
    assign bus.hourUnits = units_q;
    assign bus.dayCarry  = day_carry_q;
    assign bus.setActive = set_active_q;
endmodule

// File: tb/tb_hour_set_ctrl.sv
// Scoreboard bench for hour_set_ctrl: stimulus queues expected output changes, a monitor checks them.
module tb_hour_set_ctrl;
    typedef struct {
        logic [4:0] h;
        logic       dc;
        logic       sa;
        int         cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  nReset = 1'b0;
    int    cyc = 0;
    int    tests_run = 0;
    int    failures = 0;
    int    model_hour = 0;
    bit    mon_en = 1'b0;
    logic [12:0] prev_key = '0;
    exp_t  sb[$];

    hour_set_ctrl_if bus();

    hour_set_ctrl #(.HOLD_CYCLES(20), .REPEAT_CYCLES(8), .HOURS(24)) dut (
        .Clk_100M (clk),
        .nReset   (nReset),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input bit dc, input bit sa, input int at);
        exp_t e;
        e.h = 5'(h); e.dc = dc; e.sa = sa; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] key;
        exp_t e;
        int   et, eu;
        if (mon_en) begin
            key = {bus.hour, bus.hourTens, bus.hourUnits, bus.dayCarry, bus.setActive};
            if (key !== prev_key) begin
                tests_run++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: hour=%0d tens=%0d units=%0d dayCarry=%0b setActive=%0b at cycle %0d, required no change",
                             bus.hour, bus.hourTens, bus.hourUnits, bus.dayCarry, bus.setActive, cyc);
                end else begin
                    e  = sb.pop_front();
                    et = int'(e.h) / 10;
                    eu = int'(e.h) % 10;
                    if (bus.hour !== e.h || int'(bus.hourTens) != et || int'(bus.hourUnits) != eu ||
                        bus.dayCarry !== e.dc || bus.setActive !== e.sa || (e.cyc >= 0 && e.cyc != cyc)) begin
                        failures++;
                        $display("FAIL event: got hour=%0d tens=%0d units=%0d dc=%0b sa=%0b cyc=%0d, required hour=%0d tens=%0d units=%0d dc=%0b sa=%0b cyc=%0d",
                                 bus.hour, bus.hourTens, bus.hourUnits, bus.dayCarry, bus.setActive, cyc,
                                 e.h, et, eu, e.dc, e.sa, e.cyc);
                    end
                end
            end
            prev_key = key;
        end
    end

    task automatic carry();
        int  c;
        bit  dc;
        c  = cyc;
        dc = (model_hour == 23);
        model_hour = (model_hour == 23) ? 0 : model_hour + 1;
        bus.hourCarry = 1'b1;
        push(model_hour, dc, 1'b0, c + 1);
        if (dc) push(model_hour, 1'b0, 1'b0, c + 2);
        tick();
        bus.hourCarry = 1'b0;
        tick();
    endtask

    task automatic press_release(input int hi, input int h);
        int c;
        c = cyc;
        bus.debounced = 1'b1;
        push(h, 1'b0, 1'b0, c + 1);
        push(h, 1'b0, 1'b1, c + 2);
        push(h, 1'b0, 1'b0, c + hi + 2);
        repeat (hi) tick();
        bus.debounced = 1'b0;
        repeat (3) tick();
        model_hour = h;
    endtask

    task automatic press_carry(input int hi, input int h, input bit dc);
        int c;
        c = cyc;
        bus.debounced = 1'b1;
        bus.hourCarry = 1'b1;
        push(h, dc, 1'b0, c + 1);
        push(h, 1'b0, 1'b1, c + 2);
        push(h, 1'b0, 1'b0, c + hi + 2);
        tick();
        bus.hourCarry = 1'b0;
        repeat (hi - 1) tick();
        bus.debounced = 1'b0;
        repeat (3) tick();
        model_hour = h;
    endtask

    initial begin
        int c;
        bus.debounced = 1'b1;
        bus.hourCarry = 1'b0;
        repeat (3) tick();
        nReset = 1'b1;
        check("reset_hour", int'(bus.hour), 0);
        check("reset_tens", int'(bus.hourTens), 0);
        check("reset_units", int'(bus.hourUnits), 0);
        check("reset_dayCarry", int'(bus.dayCarry), 0);
        check("reset_setActive", int'(bus.setActive), 0);
        mon_en = 1'b1;

        // Button held through reset release must not step.
        repeat (5) tick();
        bus.debounced = 1'b0;
        repeat (2) tick();
        check("held_at_reset_no_step", int'(bus.hour), 0);

        // Press and hold: steps at offsets 0, 20, 28, 36.
        c = cyc;
        bus.debounced = 1'b1;
        push(1, 1'b0, 1'b0, c + 1);
        push(1, 1'b0, 1'b1, c + 2);
        push(2, 1'b0, 1'b1, c + 21);
        push(3, 1'b0, 1'b1, c + 29);
        push(4, 1'b0, 1'b1, c + 37);
        push(4, 1'b0, 1'b0, c + 43);
        repeat (41) tick();
        bus.debounced = 1'b0;
        repeat (3) tick();
        model_hour = 4;

        carry();
        press_release(10, 6);
        press_release(1, 7);
        model_hour = 7;

        while (model_hour != 23) carry();
        carry();
        repeat (23) carry();
        press_release(2, 0);

        repeat (23) carry();
        press_carry(2, 1, 1'b1);
        repeat (21) carry();
        press_carry(2, 0, 1'b0);

        // Reset asserted mid-REPEAT aborts immediately.
        c = cyc;
        bus.debounced = 1'b1;
        push(1, 1'b0, 1'b0, c + 1);
        push(1, 1'b0, 1'b1, c + 2);
        push(2, 1'b0, 1'b1, c + 21);
        repeat (25) tick();
        nReset = 1'b0;
        push(0, 1'b0, 1'b0, c + 25);
        #1;
        check("async_rst_hour", int'(bus.hour), 0);
        check("async_rst_tens", int'(bus.hourTens), 0);
        check("async_rst_units", int'(bus.hourUnits), 0);
        check("async_rst_dayCarry", int'(bus.dayCarry), 0);
        check("async_rst_setActive", int'(bus.setActive), 0);
        bus.debounced = 1'b0;
        tick();
        nReset = 1'b1;
        model_hour = 0;
        repeat (5) tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
